// File: rtl/dma_copy_engine.sv
// Bus-initiator DMA copy engine: moves cfg_len words from cfg_src to cfg_dst over a shared tri-state bus.
// Optional build macro DMA_FIXED_ADDR_EN adds per-transfer fixed-address flags for IO-port streaming.
module dma_copy_engine #(
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
`ifdef DMA_FIXED_ADDR_EN
  input  logic             cfg_src_fix,
  input  logic             cfg_dst_fix,
`endif
  output logic             busy,
  output logic             done,
  output logic             Bus_Req,
  input  logic             Bus_Grant,
  output logic [31:0]      address_Bus,
  inout  wire  [31:0]      Data_Bus,
  output logic             Read_DMA,
  output logic             Write_DMA
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [LEN_W-1:0]  r_cnt;
  logic [31:0]       r_wbuf;
  logic [LAT_W-1:0]  r_lat;
  logic              r_src_fix;
  logic              r_dst_fix;
  logic              w_addr_en;
  logic              w_data_en;
  logic              w_lat_last;
  logic              w_accept;
  logic [31:0]       w_src_step;
  logic [31:0]       w_dst_step;

  assign w_accept   = (r_state == S_IDLE) && start && (cfg_len != '0);
  assign w_lat_last = (r_lat == LAT_W'(RD_LAT - 1));
  assign w_src_step = r_src_fix ? 32'd0 : 32'd1;
  assign w_dst_step = r_dst_fix ? 32'd0 : 32'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (cfg_len != '0) ? S_REQ : S_DONE;
      S_REQ:  if (Bus_Grant) w_next = S_RD;
      S_RD:   if (w_lat_last) w_next = S_CAP;
      S_CAP:  w_next = S_WR;
      S_WR: begin
        if (r_cnt == LEN_W'(1)) w_next = S_DONE;
        else if (Bus_Grant)     w_next = S_RD;
        else                    w_next = S_REQ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Every bus-facing control is a pure decode of r_state, so no input reaches an output combinationally
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    Bus_Req   = 1'b0;
    Read_DMA  = 1'b0;
    Write_DMA = 1'b0;
    w_addr_en = 1'b0;
    w_data_en = 1'b0;
    case (r_state)
      S_REQ: Bus_Req = 1'b1;
      S_RD, S_CAP: begin
        Bus_Req   = 1'b1;
        Read_DMA  = 1'b1;
        w_addr_en = 1'b1;
      end
      S_WR: begin
        Bus_Req   = 1'b1;
        Write_DMA = 1'b1;
        w_addr_en = 1'b1;
        w_data_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign address_Bus = w_addr_en ? ((r_state == S_WR) ? r_dst : r_src) : 32'bz;
  assign Data_Bus    = w_data_en ? r_wbuf : 32'bz;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_wbuf    <= '0;
      r_lat     <= '0;
      r_src_fix <= 1'b0;
      r_dst_fix <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src <= cfg_src;
        r_dst <= cfg_dst;
        r_cnt <= cfg_len;
`ifdef DMA_FIXED_ADDR_EN
        r_src_fix <= cfg_src_fix;
        r_dst_fix <= cfg_dst_fix;
`else
        r_src_fix <= 1'b0;
        r_dst_fix <= 1'b0;
`endif
      end
      r_lat <= (r_state == S_RD) ? r_lat + LAT_W'(1) : '0;
      if (r_state == S_CAP) r_wbuf <= Data_Bus;
      // Pointers advance on every WR, including the last word; they are reloaded on the next start
      if (r_state == S_WR) begin
        r_cnt <= r_cnt - LEN_W'(1);
        r_src <= r_src + w_src_step;
        r_dst <= r_dst + w_dst_step;
      end
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Testbench for dma_copy_engine: table of directed transfers plus randomized transfers against a word-list model.
module tb_dma_copy_engine;
  localparam int RD_LAT = 1;
  localparam int LEN_W  = 16;
  localparam int WC     = RD_LAT + 2;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b1;
  logic             start = 1'b0;
  logic             Bus_Grant = 1'b1;
  logic [31:0]      cfg_src = '0;
  logic [31:0]      cfg_dst = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             src_fix = 1'b0;
  logic             dst_fix = 1'b0;
  wire              busy, done, Bus_Req, Read_DMA, Write_DMA;
  wire  [31:0]      address_Bus;
  wire  [31:0]      Data_Bus;

  dma_copy_engine #(.RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
`ifdef DMA_FIXED_ADDR_EN
    .cfg_src_fix(src_fix), .cfg_dst_fix(dst_fix),
`endif
    .busy(busy), .done(done), .Bus_Req(Bus_Req), .Bus_Grant(Bus_Grant),
    .address_Bus(address_Bus), .Data_Bus(Data_Bus),
    .Read_DMA(Read_DMA), .Write_DMA(Write_DMA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'd100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Responder: registers on a read-strobe edge, drives the bus while the read continues
  logic        rd_q = 1'b0;
  logic [31:0] resp_data = '0;
  assign Data_Bus = (rd_q && Read_DMA) ? resp_data : 32'bz;
  always @(posedge CLK) begin
    rd_q <= Read_DMA;
    if (Read_DMA) resp_data <= memf(address_Bus);
  end

  logic        mon_en = 1'b0;
  logic [31:0] rd_addrs[$];
  logic [63:0] wr_log[$];
  int n_done, n_req, n_both, n_noreq;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (Read_DMA) rd_addrs.push_back(address_Bus);
      if (Write_DMA) wr_log.push_back({address_Bus, Data_Bus});
      if (done) n_done++;
      if (Bus_Req) n_req++;
      if (Read_DMA && Write_DMA) n_both++;
      if ((Read_DMA || Write_DMA) && !Bus_Req) n_noreq++;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    string       nm;
    int          len;
    logic [31:0] src;
    logic [31:0] dst;
    bit          sf;
    bit          df;
    int          drop_at;
    int          bp_at;
    int          rst_at;
    int          exp_done;
  } vec_t;

  task automatic run_xfer(input vec_t v, input bit rnd_grant);
    logic [31:0] exp_rd[$];
    logic [63:0] exp_wr[$];
    logic [31:0] a;
    int got_done = -1;
    int n_ungr = 0;
    int n_ungr_noreq = 0;
    int bound = 200 + v.len * 20;
    src_fix = v.sf;
    dst_fix = v.df;
    // Model: word i reads src(+i) for RD_LAT+1 cycles from cycle 2+i*WC, writes at cycle 1+(i+1)*WC
    for (int i = 0; i < v.len; i++) begin
      a = v.src + (src_fix ? 32'd0 : 32'(i));
      for (int r = 0; r <= RD_LAT; r++)
        if (v.rst_at < 0 || 2 + i * WC + r <= v.rst_at) exp_rd.push_back(a);
      if (v.rst_at < 0 || 1 + (i + 1) * WC < v.rst_at)
        exp_wr.push_back({v.dst + (dst_fix ? 32'd0 : 32'(i)), memf(a)});
    end
    rd_addrs.delete(); wr_log.delete();
    n_done = 0; n_req = 0; n_both = 0; n_noreq = 0;
    @(negedge CLK);
    mon_en = 1'b1;
    cfg_src = v.src; cfg_dst = v.dst; cfg_len = LEN_W'(v.len); start = 1'b1;
    @(posedge CLK);
    for (int cyc = 1; cyc <= bound; cyc++) begin
      @(negedge CLK);
      if (cyc == v.bp_at) begin
        cfg_src = 32'hBAD0_0000; cfg_dst = 32'hBAD1_0000; cfg_len = LEN_W'(5); start = 1'b1;
      end else start = 1'b0;
      if (cyc == 1) chk({v.nm, " busy after start"}, 64'(busy), 64'd1);
      if (!Bus_Grant) begin
        if (Read_DMA || Write_DMA) n_ungr++;
        if (!Bus_Req) n_ungr_noreq++;
      end
      if (rnd_grant) Bus_Grant = ($urandom_range(0, 3) != 0);
      if (cyc == v.drop_at) Bus_Grant = 1'b0;
      if (v.drop_at >= 0 && cyc == v.drop_at + 5) Bus_Grant = 1'b1;
      if (cyc == v.rst_at) begin
        #2 RST_N = 1'b0;
        #1;
        chk({v.nm, " rst outputs"}, {59'd0, busy, done, Bus_Req, Read_DMA, Write_DMA}, 64'd0);
        @(negedge CLK);
        chk({v.nm, " rst held idle"}, {61'd0, busy, Read_DMA, Write_DMA}, 64'd0);
        #2 RST_N = 1'b1;
        break;
      end
      if (done) begin
        got_done = cyc;
        break;
      end
    end
    start = 1'b0;
    Bus_Grant = 1'b1;
    if (v.rst_at < 0 && got_done < 0) chk({v.nm, " done timeout"}, 64'd0, 64'd1);
    repeat (3) @(negedge CLK);
    mon_en = 1'b0;
    if (v.exp_done >= 0) chk({v.nm, " done cycle"}, 64'(got_done), 64'(v.exp_done));
    chk({v.nm, " done count"}, 64'(n_done), (v.rst_at < 0) ? 64'd1 : 64'd0);
    chk({v.nm, " idle after"}, {62'd0, busy, done}, 64'd0);
    chk({v.nm, " write count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      chk($sformatf("%s write %0d addr/data", v.nm, i), wr_log[i], exp_wr[i]);
    chk({v.nm, " read count"}, 64'(rd_addrs.size()), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_addrs.size(); i++)
      chk($sformatf("%s read %0d addr", v.nm, i), 64'(rd_addrs[i]), 64'(exp_rd[i]));
    chk({v.nm, " strobe overlap/noreq"}, 64'(n_both + n_noreq), 64'd0);
    if (v.len == 0) chk({v.nm, " no Bus_Req"}, 64'(n_req), 64'd0);
    if (v.drop_at >= 0) begin
      chk({v.nm, " strobes while ungranted"}, 64'(n_ungr), 64'd0);
      chk({v.nm, " Bus_Req dropped while ungranted"}, 64'(n_ungr_noreq), 64'd0);
    end
    if (v.len > 0 && v.drop_at < 0 && v.rst_at < 0 && !rnd_grant)
      chk({v.nm, " Bus_Req cycles"}, 64'(n_req), 64'(1 + v.len * WC));
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    #2 RST_N = 1'b0;
    #1;
    chk("reset outputs", {59'd0, busy, done, Bus_Req, Read_DMA, Write_DMA}, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    chk("reset held", {61'd0, busy, Read_DMA, Write_DMA}, 64'd0);
    #2 RST_N = 1'b1;

    tbl.push_back('{"T1 single", 1, 32'd100, 32'd200, 0, 0, -1, -1, -1, 2 + WC});
    tbl.push_back('{"T2 burst", 4, 32'h10, 32'h40, 0, 0, -1, -1, -1, 2 + 4 * WC});
    tbl.push_back('{"T3 grant drop", 3, 32'h20, 32'h60, 0, 0, 1 + WC, -1, -1, 2 + 3 * WC + 5});
    tbl.push_back('{"T4 len0", 0, 32'h55, 32'h66, 0, 0, -1, -1, -1, 1});
    tbl.push_back('{"T4 start busy", 2, 32'h70, 32'h90, 0, 0, -1, 3, -1, 2 + 2 * WC});
    tbl.push_back('{"T5 reset", 4, 32'h300, 32'h400, 0, 0, -1, -1, 2 + WC + RD_LAT, -1});
    tbl.push_back('{"T5 after", 2, 32'h500, 32'h600, 0, 0, -1, -1, -1, 2 + 2 * WC});
    tbl.push_back('{"wrap", 3, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, -1, -1, -1, 2 + 3 * WC});
`ifdef DMA_FIXED_ADDR_EN
    tbl.push_back('{"T6 fixed src", 3, 32'd1001, 32'h80, 1, 0, -1, -1, -1, 2 + 3 * WC});
    tbl.push_back('{"fixed dst", 3, 32'h90, 32'd1001, 0, 1, -1, -1, -1, 2 + 3 * WC});
`endif
    foreach (tbl[i]) run_xfer(tbl[i], 1'b0);

    for (int k = 0; k < 10; k++) begin
      rv.nm = $sformatf("rand%0d", k);
      rv.len = $urandom_range(1, 6);
      rv.src = (k % 3 == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
      rv.dst = $urandom;
      rv.sf = 1'b0;
      rv.df = 1'b0;
`ifdef DMA_FIXED_ADDR_EN
      rv.sf = 1'($urandom_range(0, 1));
      rv.df = 1'($urandom_range(0, 1));
`endif
      rv.drop_at = -1;
      rv.bp_at = -1;
      rv.rst_at = -1;
      rv.exp_done = -1;
      run_xfer(rv, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
